// File: rtl/ram32x4_arbiter.sv
// rtl/ram32x4_arbiter.sv - two-requester req/gnt arbiter and clear engine for one ram32x4
// Optional feature macro: RAM_ARB_FIXED_PRIO_EN (A always wins ties instead of round-robin).
module ram32x4_arbiter #(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 4,
  parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic              rv_a, rv_b, done_q;
  logic              tie_a;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign tie_a = 1'b1;
`else
  logic last_b;
  // Remember which port won most recently; reset to B so A wins the first tie
  always_ff @(posedge clk) begin
    if (!resetn)    last_b <= 1'b1;
    else if (gnt_a) last_b <= 1'b0;
    else if (gnt_b) last_b <= 1'b1;
  end
  assign tie_a = last_b;
`endif

  // Next state, grant selection and RAM port steering
  always_comb begin
    state_nx    = state;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (resetn) begin
      unique case (state)
        IDLE: begin
          // A clear command wins over any request presented in the same cycle
          if (clear_start) begin
            state_nx = CLEAR;
          end else if (req_a && (!req_b || tie_a)) begin
            gnt_a       = 1'b1;
            ram_address = addr_a;
            ram_data    = wdata_a;
            ram_wren    = we_a;
          end else if (req_b) begin
            gnt_b       = 1'b1;
            ram_address = addr_b;
            ram_data    = wdata_b;
            ram_wren    = we_b;
          end
        end
        CLEAR: begin
          ram_wren    = 1'b1;
          ram_address = cnt;
          ram_data    = FILL_VALUE;
          if (cnt == LAST_ADDR) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register, clear walk counter, read-valid and clear-done pipeline
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      rv_a   <= 1'b0;
      rv_b   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      rv_a   <= gnt_a & ~we_a;
      rv_b   <= gnt_b & ~we_b;
      done_q <= (state == CLEAR) && (cnt == LAST_ADDR);
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  // Registered flags are masked while reset is held so a pending read never reports valid
  assign rvalid_a   = rv_a & resetn;
  assign rvalid_b   = rv_b & resetn;
  assign clear_done = done_q & resetn;
  assign busy       = (state == CLEAR);
  assign rdata      = ram_q;

endmodule
